// File: rtl/seq_byte_packer.sv
// Packs an accepted valid/ready byte stream into LANES-byte words with a lane-keep mask,
// closing words early on in_last and counting delivered packets with saturation.
module seq_byte_packer #(
    parameter int DATA_W = 8,
    parameter int LANES  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_data,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W*LANES-1:0]   out_data,
    output logic [LANES-1:0]          out_keep,
    output logic                      out_last,
    output logic [CNT_W-1:0]          pkt_count
);

    localparam int IDX_W  = $clog2(LANES);
    localparam int WORD_W = DATA_W * LANES;

    typedef enum logic {
        EMPTY,
        FILL
    } state_t;

    state_t            state, state_next;
    logic [IDX_W-1:0]  lane_idx, lane_idx_next;
    logic [WORD_W-1:0] asm_data, asm_data_next;
    logic [LANES-1:0]  asm_keep, asm_keep_next;

    logic [WORD_W-1:0] word_merged;
    logic [LANES-1:0]  keep_merged;

    logic              in_fire;
    logic              out_fire;
    logic              close_word;

    logic              out_load;
    logic              out_valid_next;

    // A full output register blocks the input unless it drains on this very edge.
    assign in_ready   = !out_valid || out_ready;
    assign in_fire    = in_valid && in_ready;
    assign out_fire   = out_valid && out_ready;
    assign close_word = in_fire && ((lane_idx == IDX_W'(LANES - 1)) || in_last);

    always_comb begin
        word_merged = asm_data;
        keep_merged = asm_keep;
        for (int i = 0; i < LANES; i++) begin
            if (lane_idx == IDX_W'(i)) begin
                word_merged[i*DATA_W +: DATA_W] = in_data;
                keep_merged[i]                  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            lane_idx <= '0;
            asm_data <= '0;
            asm_keep <= '0;
        end else begin
            state    <= state_next;
            lane_idx <= lane_idx_next;
            asm_data <= asm_data_next;
            asm_keep <= asm_keep_next;
        end
    end

    always_comb begin
        state_next    = state;
        lane_idx_next = lane_idx;
        asm_data_next = asm_data;
        asm_keep_next = asm_keep;
        if (in_fire) begin
            if (close_word) begin
                state_next    = EMPTY;
                lane_idx_next = '0;
                asm_data_next = '0;
                asm_keep_next = '0;
            end else begin
                state_next    = FILL;
                lane_idx_next = lane_idx + IDX_W'(1);
                asm_data_next = word_merged;
                asm_keep_next = keep_merged;
            end
        end
    end

    // A close on the same edge as a drain reloads the register, so out_valid never bubbles.
    always_comb begin
        out_load       = close_word;
        out_valid_next = out_valid;
        if (close_word) begin
            out_valid_next = 1'b1;
        end else if (out_fire) begin
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
        end else begin
            out_valid <= out_valid_next;
            if (out_load) begin
                out_data <= word_merged;
                out_keep <= keep_merged;
                out_last <= in_last;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_count <= '0;
        end else if (out_fire && out_last && (pkt_count != {CNT_W{1'b1}})) begin
            pkt_count <= pkt_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_seq_byte_packer.sv
// Randomized and directed checks of seq_byte_packer against a byte-queue reference model.
module tb_seq_byte_packer;

    localparam int DATA_W = 8;
    localparam int LANES  = 4;
    localparam int CNT_W  = 16;
    localparam int WORD_W = DATA_W * LANES;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_last = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [WORD_W-1:0] out_data;
    logic [LANES-1:0]  out_keep;
    logic              out_last;
    logic [CNT_W-1:0]  pkt_count;

    int cmpCount = 0;
    int errCount = 0;
    bit checkEn = 1'b1;

    logic [DATA_W-1:0] mBytes[$];
    bit                mValid = 1'b0;
    logic [WORD_W-1:0] mData = '0;
    logic [LANES-1:0]  mKeep = '0;
    bit                mLast = 1'b0;
    int                mCount = 0;
    bit                mReady;

    always #5 clk = ~clk;

    seq_byte_packer #(.DATA_W(DATA_W), .LANES(LANES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_keep(out_keep), .out_last(out_last), .pkt_count(pkt_count)
    );

    // Reference: bytes collect in a queue; a word forms when the queue reaches LANES or in_last arrives.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mBytes.delete();
            mValid = 1'b0;
            mData  = '0;
            mKeep  = '0;
            mLast  = 1'b0;
            mCount = 0;
        end else begin
            mReady = !mValid || out_ready;
            if (mValid && out_ready) begin
                if (mLast && mCount < CNT_MAX) mCount++;
                mValid = 1'b0;
            end
            if (in_valid && mReady) begin
                mBytes.push_back(in_data);
                if (mBytes.size() == LANES || in_last) begin
                    mData = '0;
                    foreach (mBytes[i]) mData = mData | (WORD_W'(mBytes[i]) << (i * DATA_W));
                    mKeep  = LANES'((1 << mBytes.size()) - 1);
                    mLast  = in_last;
                    mValid = 1'b1;
                    mBytes.delete();
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        cmpCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h, wanted %0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic compareState();
        checkOutput("out_valid", out_valid, mValid);
        if (mValid) begin
            checkOutput("out_data", out_data, mData);
            checkOutput("out_keep", out_keep, mKeep);
            checkOutput("out_last", out_last, mLast);
        end
        checkOutput("pkt_count", pkt_count, mCount);
    endtask

    task automatic applyStimulus(input bit v, input logic [DATA_W-1:0] d, input bit l, input bit r);
        @(negedge clk);
        if (checkEn) compareState();
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = r;
        #1;
        if (checkEn) checkOutput("in_ready", in_ready, !mValid || r);
    endtask

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_valid", out_valid, 0);
        checkOutput("rst_data", out_data, 0);
        checkOutput("rst_keep", out_keep, 0);
        checkOutput("rst_count", pkt_count, 0);
        rst_n = 1'b1;

        // Full word, single packet
        applyStimulus(1, 8'h11, 0, 1);
        applyStimulus(1, 8'h22, 0, 1);
        applyStimulus(1, 8'h33, 0, 1);
        applyStimulus(1, 8'h44, 1, 1);
        applyStimulus(0, 8'h00, 0, 1);
        checkOutput("t1_data", out_data, 32'h44332211);
        checkOutput("t1_keep", out_keep, 4'b1111);
        checkOutput("t1_last", out_last, 1);
        applyStimulus(0, 8'h00, 0, 1);
        checkOutput("t1_count", pkt_count, 1);

        // Short packet
        applyStimulus(1, 8'hA1, 0, 1);
        applyStimulus(1, 8'hB2, 1, 1);
        applyStimulus(0, 8'h00, 0, 1);
        checkOutput("t2_data", out_data, 32'h0000B2A1);
        checkOutput("t2_keep", out_keep, 4'b0011);
        checkOutput("t2_last", out_last, 1);

        // Two back-to-back words
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1, 8'(i), i == 8, 1);
            if (i == 5) begin
                checkOutput("t3_w0_data", out_data, 32'h04030201);
                checkOutput("t3_w0_last", out_last, 0);
            end
        end
        applyStimulus(0, 8'h00, 0, 1);
        checkOutput("t3_w1_data", out_data, 32'h08070605);
        checkOutput("t3_w1_last", out_last, 1);

        // Stall then drain with a simultaneous close
        applyStimulus(1, 8'h10, 0, 1);
        applyStimulus(1, 8'h20, 0, 1);
        applyStimulus(1, 8'h30, 0, 1);
        applyStimulus(1, 8'h40, 1, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 8'hEE, 1, 0);
            checkOutput("t4_stall_ready", in_ready, 0);
            checkOutput("t4_hold_data", out_data, 32'h40302010);
        end
        applyStimulus(1, 8'h99, 1, 1);
        applyStimulus(0, 8'h00, 0, 1);
        checkOutput("t4_nogap_valid", out_valid, 1);
        checkOutput("t4_new_data", out_data, 32'h00000099);
        applyStimulus(0, 8'h00, 0, 1);

        // Async reset mid-word
        applyStimulus(1, 8'h66, 0, 1);
        applyStimulus(1, 8'h77, 0, 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t5_rst_valid", out_valid, 0);
        checkOutput("t5_rst_data", out_data, 0);
        checkOutput("t5_rst_count", pkt_count, 0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1, 8'h55, 1, 1);
        applyStimulus(0, 8'h00, 0, 1);
        checkOutput("t5_data", out_data, 32'h00000055);
        checkOutput("t5_keep", out_keep, 4'b0001);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            applyStimulus($urandom_range(9) < 7, 8'($urandom), $urandom_range(4) == 0,
                          $urandom_range(9) < 6);
        end
        applyStimulus(0, 8'h00, 0, 1);
        applyStimulus(0, 8'h00, 0, 1);

        // Counter saturation
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkEn = 1'b0;
        for (int i = 0; i < CNT_MAX - 1; i++) applyStimulus(1, 8'(i), 1, 1);
        checkEn = 1'b1;
        applyStimulus(0, 8'h00, 0, 1);
        applyStimulus(0, 8'h00, 0, 1);
        checkOutput("sat_fffe", pkt_count, 16'hFFFE);
        applyStimulus(1, 8'h01, 1, 1);
        applyStimulus(1, 8'h02, 1, 1);
        applyStimulus(0, 8'h00, 0, 1);
        applyStimulus(0, 8'h00, 0, 1);
        checkOutput("sat_ffff", pkt_count, 16'hFFFF);
        applyStimulus(1, 8'h03, 1, 1);
        applyStimulus(0, 8'h00, 0, 1);
        applyStimulus(0, 8'h00, 0, 1);
        checkOutput("sat_hold", pkt_count, 16'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
        $finish;
    end

endmodule
